// File: rtl/sonic_gearbox_pkg.sv
// Shared constants and width helpers for the SONIC up/down gearboxes.
// No logic; elaboration-time functions only.
// Not applicable (no data path).
package sonic_gearbox_pkg;

    localparam int GB_IN_W_DEFAULT  = 40;
    localparam int GB_OUT_W_DEFAULT = 66;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a bit counter able to hold 0..in_w+out_w.
    function automatic int gb_cnt_w(input int in_w, input int out_w);
        return clog2(in_w + out_w + 1);
    endfunction

endpackage

// File: rtl/sonic_gearbox_shift_insert.sv
// Barrel shifter: places data_in at bit offset shamt in a BUF_W-bit field.
// Purely combinational, zero latency.
// No flow control; the caller guarantees shamt + IN_W <= BUF_W.
module sonic_gearbox_shift_insert #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 66,
    parameter int CNT_W = 7
) (
    input  logic [IN_W-1:0]       data_in,
    input  logic [CNT_W-1:0]      shamt,
    output logic [IN_W+OUT_W-1:0] field
);

    assign field = {{OUT_W{1'b0}}, data_in} << shamt;

endmodule

// File: rtl/sonic_gearbox_up.sv
// Narrow-to-wide gearbox: packs IN_W-bit words into OUT_W-bit words, LSB first, with bit slip.
// One cycle from the data_in completing a word to data_out/data_valid; all outputs registered.
// No backpressure: input is always accepted, at most one output word per cycle.
module sonic_gearbox_up
    import sonic_gearbox_pkg::*;
#(
    parameter  int IN_W  = GB_IN_W_DEFAULT,
    parameter  int OUT_W = GB_OUT_W_DEFAULT,
    localparam int CNT_W = gb_cnt_w(IN_W, OUT_W)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [IN_W-1:0]  data_in,
    input  logic             in_valid,
    input  logic             slip,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] fill_level
);

    localparam int BUF_W = IN_W + OUT_W;

    // IN_W < OUT_W is what bounds emission to one word per cycle.
    if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_width
        $error("sonic_gearbox_up: need 1 <= IN_W < OUT_W");
    end

    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;

    logic [BUF_W-1:0] ins_field;
    logic [BUF_W-1:0] b_app, b_slip, b_emit, buf_next;
    logic [CNT_W-1:0] n_app, n_slip, n_emit;
    logic [OUT_W-1:0] word_next;
    logic             emit;

    // New input lands just above the bits already buffered.
    sonic_gearbox_shift_insert #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_shift_insert (
        .data_in (data_in),
        .shamt   (cnt_q),
        .field   (ins_field)
    );

    // Append, then slip, then emit, on a working copy of the buffer.
    always_comb begin
        b_app     = buf_q;
        n_app     = cnt_q;
        b_slip    = '0;
        n_slip    = '0;
        b_emit    = '0;
        n_emit    = '0;
        emit      = 1'b0;
        word_next = data_out;

        if (in_valid) begin
            b_app = buf_q | ins_field;
            n_app = cnt_q + CNT_W'(IN_W);
        end

        // Slip on an empty buffer is dropped, not remembered.
        b_slip = b_app;
        n_slip = n_app;
        if (slip && (n_app != '0)) begin
            b_slip = b_app >> 1;
            n_slip = n_app - CNT_W'(1);
        end

        b_emit = b_slip;
        n_emit = n_slip;
        if (n_slip >= CNT_W'(OUT_W)) begin
            emit      = 1'b1;
            word_next = b_slip[OUT_W-1:0];
            b_emit    = b_slip >> OUT_W;
            n_emit    = n_slip - CNT_W'(OUT_W);
        end

        // Keep everything above the fill level clean so the next OR-insert is exact.
        buf_next = b_emit & ~({BUF_W{1'b1}} << n_emit);
    end

    // Commit buffer state and register every output.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            fill_level <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            buf_q      <= buf_next;
            cnt_q      <= n_emit;
            fill_level <= n_emit;
            data_out   <= word_next;
            data_valid <= emit;
        end
    end

endmodule

// File: tb/tb_sonic_gearbox_up.sv
// Directed bench for sonic_gearbox_up (40 -> 66).
// Table of hand-computed vectors, then streaming sequences against a bit-queue model.
// Inputs change after the edge, outputs sampled 1 time unit after the edge.
module tb_sonic_gearbox_up;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [39:0] data_in;
    logic        in_valid;
    logic        slip;
    logic [65:0] data_out;
    logic        data_valid;
    logic [6:0]  fill_level;

    int n_vec = 0;
    int n_err = 0;

    sonic_gearbox_up #(
        .IN_W  (40),
        .OUT_W (66)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .slip       (slip),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fill_level (fill_level)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic        rst;
        logic [39:0] din;
        logic        vld;
        logic        slp;
        logic [65:0] eo;
        logic        ev;
        logic [6:0]  ef;
    } vec_t;

    vec_t tbl[17];

    // Bit-level reference: a FIFO of bits, oldest at the front.
    bit          mq[$];
    logic [65:0] m_out;
    logic [65:0] ref_words[$];

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_cycle(input logic [39:0] d, input logic v, input logic s,
                               output logic ev, output int ef);
        if (v) for (int i = 0; i < 40; i++) mq.push_back(d[i]);
        if (s && mq.size() > 0) void'(mq.pop_front());
        ev = 1'b0;
        if (mq.size() >= 66) begin
            ev = 1'b1;
            for (int i = 0; i < 66; i++) m_out[i] = mq.pop_front();
        end
        ef = mq.size();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; slip = 1'b0; data_in = '0;
        step();
        reset = 1'b0;
        mq.delete();
        m_out = '0;
    endtask

    // mode 0: continuous, record words; 1: gapped, compare to recorded; 2: slip on first word.
    task automatic run_stream(input int mode, input int ncyc, input string tag);
        logic [39:0] k;
        logic        ev;
        int          ef;
        int          pulses;
        int          widx;
        bit          first;
        k = 40'd1; pulses = 0; widx = 0; first = 1'b1;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            in_valid = (mode == 1) ? ((c % 2) == 0) : 1'b1;
            data_in  = k;
            slip     = (mode == 2) && first && in_valid;
            if (in_valid) first = 1'b0;
            model_cycle(data_in, in_valid, slip, ev, ef);
            step();
            if (in_valid) k = k + 40'd1;
            check({tag, " valid"}, {65'd0, data_valid}, {65'd0, ev});
            check({tag, " fill"}, {59'd0, fill_level}, 66'(ef));
            check({tag, " data"}, data_out, m_out);
            if (mode == 2 && c == 0) check({tag, " fill after slip"}, {59'd0, fill_level}, 66'd39);
            if (data_valid) begin
                pulses++;
                if (mode == 0) ref_words.push_back(data_out);
                if (mode == 1) begin
                    if (widx < ref_words.size())
                        check({tag, " vs continuous"}, data_out, ref_words[widx]);
                    else
                        check({tag, " extra word"}, 66'd1, 66'd0);
                    widx++;
                end
            end
            if (mode == 0 && (c == 32 || c == 65)) begin
                check({tag, " pulses per 33"}, 66'(pulses), 66'd20);
                check({tag, " fill at period end"}, {59'd0, fill_level}, 66'd0);
                pulses = 0;
            end
        end
        in_valid = 1'b0; slip = 1'b0;
        if (mode == 1) check({tag, " word count"}, 66'(widx), 66'(ref_words.size()));
    endtask

    initial begin
        reset = 1'b1; data_in = '0; in_valid = 1'b0; slip = 1'b0;

        tbl[0]  = '{"reset",           1, 40'h0,          0, 0, 66'h0,          0, 7'd0};
        tbl[1]  = '{"ones word",       0, 40'hFF_FFFF_FFFF, 1, 0, 66'h0,        0, 7'd40};
        tbl[2]  = '{"first emit",      0, 40'h0,          1, 0, 66'h00FFFFFFFFFF, 1, 7'd14};
        tbl[3]  = '{"idle hold",       0, 40'h0,          0, 0, 66'h00FFFFFFFFFF, 0, 7'd14};
        tbl[4]  = '{"midword reset",   1, 40'h0,          1, 1, 66'h0,          0, 7'd0};
        tbl[5]  = '{"ones again",      0, 40'hFF_FFFF_FFFF, 1, 0, 66'h0,        0, 7'd40};
        tbl[6]  = '{"emit again",      0, 40'h0,          1, 0, 66'h00FFFFFFFFFF, 1, 7'd14};
        tbl[7]  = '{"reset 2",         1, 40'h0,          0, 0, 66'h0,          0, 7'd0};
        tbl[8]  = '{"idle slip",       0, 40'h0,          0, 1, 66'h0,          0, 7'd0};
        tbl[9]  = '{"idle slip held",  0, 40'h0,          0, 1, 66'h0,          0, 7'd0};
        tbl[10] = '{"load 3",          0, 40'h3,          1, 0, 66'h0,          0, 7'd40};
        tbl[11] = '{"late slip",       0, 40'h0,          0, 1, 66'h0,          0, 7'd39};
        tbl[12] = '{"emit slipped",    0, 40'h0,          1, 0, 66'h1,          1, 7'd13};
        tbl[13] = '{"reset 3",         1, 40'h0,          0, 0, 66'h0,          0, 7'd0};
        tbl[14] = '{"slip with first", 0, 40'h5,          1, 1, 66'h0,          0, 7'd39};
        tbl[15] = '{"emit dropped b0", 0, 40'h0,          1, 0, 66'h2,          1, 7'd13};
        tbl[16] = '{"reset 4",         1, 40'h0,          0, 0, 66'h0,          0, 7'd0};

        for (int i = 0; i < 17; i++) begin
            reset    = tbl[i].rst;
            data_in  = tbl[i].din;
            in_valid = tbl[i].vld;
            slip     = tbl[i].slp;
            step();
            check({tbl[i].name, " data_out"}, data_out, tbl[i].eo);
            check({tbl[i].name, " data_valid"}, {65'd0, data_valid}, {65'd0, tbl[i].ev});
            check({tbl[i].name, " fill_level"}, {59'd0, fill_level}, {59'd0, tbl[i].ef});
        end

        run_stream(0, 66,  "continuous");
        check("continuous word total", 66'(ref_words.size()), 66'd40);
        run_stream(1, 132, "gapped");
        run_stream(2, 66,  "slip");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
